cluster_mem_arbiter: RTL and testbench
======================================

// Module: cluster_mem_arbiter
// PURPOSE
//   Next-generation cluster memory front end. It arbitrates NUM_CORES x CH_PER_CORE request channels
//   (per core: ch0=I-fetch, ch1=D-access, ...) onto one memory-controller port.
//   Each accepted request is tracked in an in-order tag FIFO, and its response is routed back to the
//   originating channel. Adds a selectable arbitration mode, starvation protection, per-core masking
//   and outstanding-request limiting.
// PARAMETERS
//   NUM_CORES        4   cores in cluster
//   CH_PER_CORE      2   request channels per core; NUM_CH = NUM_CORES*CH_PER_CORE (localparam)
//   ADDR_W           32  address width
//   DATA_W           32  data width
//   MAX_OUTSTANDING  4   tag FIFO depth (>=1); max in-flight requests
//   ARB_MODE         0   0 = round-robin, 1 = fixed priority (lowest index) with starvation override
//   STARVE_LIMIT     15  fixed mode only: waiting-cycle count that forces a grant (>=1)
// PORTS
//   clk_i            in   1               clock
//   rst_i            in   1               async reset, active-high
//   core_enable_i    in   NUM_CORES       0 masks all channels of that core from arbitration
//   req_valid_i      in   NUM_CH          per-channel request valid
//   req_ready_o      out  NUM_CH          one-hot accept strobe
//   req_we_i         in   NUM_CH          1 = write
//   req_addr_i       in   NUM_CH*ADDR_W   channel c at [c*ADDR_W +: ADDR_W]
//   req_wdata_i      in   NUM_CH*DATA_W   channel c at [c*DATA_W +: DATA_W]
//   mem_req_valid_o  out  1               request to memory controller
//   mem_req_ready_i  in   1               controller accepts
//   mem_req_we_o     out  1               write flag
//   mem_req_addr_o   out  ADDR_W          address
//   mem_req_wdata_o  out  DATA_W          write data
//   mem_rsp_valid_i  in   1               in-order response; one per request, including writes
//   mem_rsp_rdata_i  in   DATA_W          response data
//   rsp_valid_o      out  NUM_CH          one-hot response strobe to the originating channel
//   rsp_rdata_o      out  DATA_W          response data, shared by all channels
//   outstanding_o    out  $clog2(MAX_OUTSTANDING+1)  in-flight request count
//   busy_o           out  1               mem_req_valid_o | (outstanding_o != 0)
//   rsp_err_o        out  1               sticky: response received with no tag outstanding
// BEHAVIOUR
//   - Reset: all outputs 0; RR pointer 0; starvation counters 0; tag FIFO empty; output register empty.
//   - Eligibility: req_valid_i[c] & core_enable_i[c/CH_PER_CORE].
//   - Arbitration enable: (!mem_req_valid_o | mem_req_ready_i) & (outstanding_o < MAX_OUTSTANDING).
//     A same-cycle response pop does not free a slot.
//   - When enabled with >=1 eligible channel: exactly one grant g. In that cycle req_ready_o[g]=1,
//     the request is loaded into the output register, and g is pushed to the tag FIFO.
//   - Latency: accepted in cycle N, presented on mem_req_* in cycle N+1.
//   - mem_req_* hold stable while mem_req_valid_o & !mem_req_ready_i.
//   - Back-to-back: a new grant may load in the same cycle the old request handshakes.
//   - Requesters hold valid/we/addr/wdata stable until accepted. The arbiter never accepts without a grant.
//   - RR mode: search starts at ptr and wraps NUM_CH-1 -> 0; on grant, ptr <= (g+1) mod NUM_CH.
//   - Fixed mode: per-channel saturating counter. It increments while the channel is eligible, arbitration
//     is enabled and the channel is not granted. It clears on grant or when the channel is not eligible.
//     Any channel whose counter is >= STARVE_LIMIT wins (lowest such index); otherwise the lowest eligible
//     index wins. Counters stay 0 in RR mode.
//   - Tag FIFO: circular, depth MAX_OUTSTANDING; pointers wrap at MAX_OUTSTANDING.
//     Push on grant; pop on mem_rsp_valid_i while not empty. Simultaneous push and pop leaves the count
//     unchanged.
//   - Response: rsp_valid_o = onehot(head) & {NUM_CH{mem_rsp_valid_i & !empty}};
//     rsp_rdata_o = mem_rsp_rdata_i. This path is combinational (0 cycles) with no back-pressure.
//   - mem_rsp_valid_i while empty: the response is dropped, rsp_valid_o stays 0, and rsp_err_o is set
//     (cleared only by reset).
//   - Deasserting core_enable_i only blocks new grants. Outstanding responses to that core are still
//     delivered.
//   - Reset mid-transaction: all state clears immediately (async). Responses arriving after release set
//     rsp_err_o.
// TESTING
//   1. RR, NUM_CH=8, all valid, mem_req_ready_i=1, fast responses -> grants 0,1,..,7,0 in successive
//      cycles; each mem_req appears 1 cycle after its req_ready_o.
//   2. Fixed, STARVE_LIMIT=3, ch0 and ch5 always valid -> ch0 granted 3 times, then ch5 granted on the
//      4th arbitration; the pattern repeats.
//   3. MAX_OUTSTANDING=4, no responses -> exactly 4 grants, then req_ready_o=0 and outstanding_o=4.
//      One response frees one slot: the next grant comes the cycle after the pop.
//   4. Grants ch3, ch6, ch1; responses D0, D1, D2 -> rsp_valid_o[3]/D0, then [6]/D1, then [1]/D2,
//      same cycle as each mem_rsp_valid_i.
//   5. mem_req_ready_i=0 for 5 cycles with a request pending -> mem_req_* stable, no new grant.
//      Ready released -> handshake, and a new grant in the same cycle.
//   6. core_enable_i=4'b1101 with all valid -> channels 2 and 3 are never granted.
//      A stray mem_rsp_valid_i when empty -> rsp_err_o=1 and held until rst_i.

Source files
------------

// File: rtl/cluster_mem_arbiter_if.sv
// Request/response bundle between the cluster channels, the arbiter and the memory controller.
// The slave modport is the arbiter's view; master is the cluster/controller side.
interface cluster_mem_arbiter_if #(
  parameter int NUM_CORES       = 4,
  parameter int CH_PER_CORE     = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
);
  localparam int NUM_CH = NUM_CORES * CH_PER_CORE;
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);

  logic [NUM_CORES-1:0]     core_enable_i;
  logic [NUM_CH-1:0]        req_valid_i;
  logic [NUM_CH-1:0]        req_ready_o;
  logic [NUM_CH-1:0]        req_we_i;
  logic [NUM_CH*ADDR_W-1:0] req_addr_i;
  logic [NUM_CH*DATA_W-1:0] req_wdata_i;
  logic                     mem_req_valid_o;
  logic                     mem_req_ready_i;
  logic                     mem_req_we_o;
  logic [ADDR_W-1:0]        mem_req_addr_o;
  logic [DATA_W-1:0]        mem_req_wdata_o;
  logic                     mem_rsp_valid_i;
  logic [DATA_W-1:0]        mem_rsp_rdata_i;
  logic [NUM_CH-1:0]        rsp_valid_o;
  logic [DATA_W-1:0]        rsp_rdata_o;
  logic [OUT_W-1:0]         outstanding_o;
  logic                     busy_o;
  logic                     rsp_err_o;

  modport slave (
    input  core_enable_i, req_valid_i, req_we_i, req_addr_i, req_wdata_i,
           mem_req_ready_i, mem_rsp_valid_i, mem_rsp_rdata_i,
    output req_ready_o, mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o,
           rsp_valid_o, rsp_rdata_o, outstanding_o, busy_o, rsp_err_o
  );

  modport master (
    output core_enable_i, req_valid_i, req_we_i, req_addr_i, req_wdata_i,
           mem_req_ready_i, mem_rsp_valid_i, mem_rsp_rdata_i,
    input  req_ready_o, mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o,
           rsp_valid_o, rsp_rdata_o, outstanding_o, busy_o, rsp_err_o
  );
endinterface

// File: rtl/cluster_mem_arbiter.sv
// Cluster memory front end: arbitrates all core channels onto one controller port and routes
// in-order responses back through a tag FIFO of granted channel indices.
module cluster_mem_arbiter #(
  parameter int NUM_CORES       = 4,
  parameter int CH_PER_CORE     = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ARB_MODE        = 0,
  parameter int STARVE_LIMIT    = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  cluster_mem_arbiter_if.slave bus
);
  localparam int NUM_CH = NUM_CORES * CH_PER_CORE;
  localparam int TAG_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);

  function automatic logic [SCNT_W-1:0] sat_inc(input logic [SCNT_W-1:0] v);
    return (v >= SCNT_W'(STARVE_LIMIT)) ? v : v + SCNT_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic [NUM_CH-1:0] elig;
  logic              arb_en;
  logic              gnt_any;
  logic [TAG_W-1:0]  gnt_idx;
  logic [TAG_W-1:0]  rr_ptr;
  logic [SCNT_W-1:0] starve_cnt [NUM_CH];

  logic              req_vld_p1;
  logic              req_we_p1;
  logic [ADDR_W-1:0] req_addr_p1;
  logic [DATA_W-1:0] req_wdata_p1;

  logic [TAG_W-1:0]  tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;
  logic              rsp_err_q;
  logic              push, pop;

  always_comb begin
    elig = '0;
    for (int c = 0; c < NUM_CH; c++)
      elig[c] = bus.req_valid_i[c] & bus.core_enable_i[c / CH_PER_CORE];
  end

  // A pop in the same cycle does not free a slot: the limit uses the registered count only.
  assign arb_en = !rst_i && (!req_vld_p1 || bus.mem_req_ready_i) &&
                  (count_q < CNT_W'(MAX_OUTSTANDING));

  // Descending scans so the last hit, i.e. the highest-priority candidate, wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (arb_en) begin
      if (ARB_MODE == 0) begin
        for (int i = NUM_CH - 1; i >= 0; i--) begin
          if (elig[(int'(rr_ptr) + i) % NUM_CH]) begin
            gnt_any = 1'b1;
            gnt_idx = TAG_W'((int'(rr_ptr) + i) % NUM_CH);
          end
        end
      end else begin
        for (int c = NUM_CH - 1; c >= 0; c--) begin
          if (elig[c] && starve_cnt[c] >= SCNT_W'(STARVE_LIMIT)) begin
            gnt_any = 1'b1;
            gnt_idx = TAG_W'(c);
          end
        end
        if (!gnt_any) begin
          for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (elig[c]) begin
              gnt_any = 1'b1;
              gnt_idx = TAG_W'(c);
            end
          end
        end
      end
    end
  end

  always_comb begin
    bus.req_ready_o = '0;
    if (gnt_any) bus.req_ready_o[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
      for (int c = 0; c < NUM_CH; c++) starve_cnt[c] <= '0;
    end else begin
      if (ARB_MODE == 0 && gnt_any)
        rr_ptr <= (gnt_idx == TAG_W'(NUM_CH - 1)) ? '0 : gnt_idx + TAG_W'(1);
      if (ARB_MODE != 0) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (!elig[c] || (gnt_any && gnt_idx == TAG_W'(c))) starve_cnt[c] <= '0;
          else if (arb_en)                                    starve_cnt[c] <= sat_inc(starve_cnt[c]);
        end
      end
    end
  end

  // Stage p1: granted request held toward the memory controller.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_vld_p1   <= 1'b0;
      req_we_p1    <= 1'b0;
      req_addr_p1  <= '0;
      req_wdata_p1 <= '0;
    end else if (gnt_any) begin
      req_vld_p1   <= 1'b1;
      req_we_p1    <= bus.req_we_i[gnt_idx];
      req_addr_p1  <= bus.req_addr_i[int'(gnt_idx) * ADDR_W +: ADDR_W];
      req_wdata_p1 <= bus.req_wdata_i[int'(gnt_idx) * DATA_W +: DATA_W];
    end else if (bus.mem_req_ready_i) begin
      req_vld_p1   <= 1'b0;
    end
  end

  assign push = gnt_any;
  assign pop  = bus.mem_rsp_valid_i && (count_q != '0);

  always_ff @(posedge clk_i) begin
    if (push) tag_mem[tail_q] <= gnt_idx;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (push) tail_q <= ptr_inc(tail_q);
      if (pop)  head_q <= ptr_inc(head_q);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (!push && pop) count_q <= count_q - CNT_W'(1);
      if (bus.mem_rsp_valid_i && count_q == '0) rsp_err_q <= 1'b1;
    end
  end

  always_comb begin
    bus.rsp_valid_o = '0;
    if (pop) bus.rsp_valid_o[tag_mem[head_q]] = 1'b1;
  end

  assign bus.rsp_rdata_o     = bus.mem_rsp_rdata_i;
  assign bus.mem_req_valid_o = req_vld_p1;
  assign bus.mem_req_we_o    = req_we_p1;
  assign bus.mem_req_addr_o  = req_addr_p1;
  assign bus.mem_req_wdata_o = req_wdata_p1;
  assign bus.outstanding_o   = count_q;
  assign bus.busy_o          = req_vld_p1 | (count_q != '0);
  assign bus.rsp_err_o       = rsp_err_q;
endmodule

// File: tb/tb_cluster_mem_arbiter.sv
// Random-stimulus bench: one round-robin and one fixed-priority arbiter, each exercised in turn
// against a queue-based reference model of the grant, tag and response rules.
module tb_cluster_mem_arbiter;
  localparam int NUM_CORES   = 4;
  localparam int CH_PER_CORE = 2;
  localparam int NUM_CH      = NUM_CORES * CH_PER_CORE;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int MAXO        = 4;
  localparam int SL          = 3;
  localparam int OUT_W       = $clog2(MAXO + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cluster_mem_arbiter_if #(.NUM_CORES(NUM_CORES), .CH_PER_CORE(CH_PER_CORE), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .MAX_OUTSTANDING(MAXO)) ifc_rr ();
  cluster_mem_arbiter_if #(.NUM_CORES(NUM_CORES), .CH_PER_CORE(CH_PER_CORE), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .MAX_OUTSTANDING(MAXO)) ifc_fx ();

  cluster_mem_arbiter #(.NUM_CORES(NUM_CORES), .CH_PER_CORE(CH_PER_CORE), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .MAX_OUTSTANDING(MAXO), .ARB_MODE(0), .STARVE_LIMIT(15))
    dut_rr (.clk_i(clk), .rst_i(rst), .bus(ifc_rr));
  cluster_mem_arbiter #(.NUM_CORES(NUM_CORES), .CH_PER_CORE(CH_PER_CORE), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .MAX_OUTSTANDING(MAXO), .ARB_MODE(1), .STARVE_LIMIT(SL))
    dut_fx (.clk_i(clk), .rst_i(rst), .bus(ifc_fx));

  int cur;
  logic [NUM_CORES-1:0]     core_en;
  logic [NUM_CH-1:0]        vld, we;
  logic [NUM_CH*ADDR_W-1:0] addr;
  logic [NUM_CH*DATA_W-1:0] wdata;
  logic                     mem_ready, rsp_vld;
  logic [DATA_W-1:0]        rsp_data;

  assign ifc_rr.core_enable_i   = (cur == 0) ? core_en : '0;
  assign ifc_rr.req_valid_i     = (cur == 0) ? vld : '0;
  assign ifc_rr.req_we_i        = we;
  assign ifc_rr.req_addr_i      = addr;
  assign ifc_rr.req_wdata_i     = wdata;
  assign ifc_rr.mem_req_ready_i = mem_ready;
  assign ifc_rr.mem_rsp_valid_i = (cur == 0) ? rsp_vld : 1'b0;
  assign ifc_rr.mem_rsp_rdata_i = rsp_data;
  assign ifc_fx.core_enable_i   = (cur == 1) ? core_en : '0;
  assign ifc_fx.req_valid_i     = (cur == 1) ? vld : '0;
  assign ifc_fx.req_we_i        = we;
  assign ifc_fx.req_addr_i      = addr;
  assign ifc_fx.req_wdata_i     = wdata;
  assign ifc_fx.mem_req_ready_i = mem_ready;
  assign ifc_fx.mem_rsp_valid_i = (cur == 1) ? rsp_vld : 1'b0;
  assign ifc_fx.mem_rsp_rdata_i = rsp_data;

  logic [NUM_CH-1:0] o_ready, o_rsp;
  logic              o_mvld, o_mwe, o_busy, o_err;
  logic [ADDR_W-1:0] o_maddr;
  logic [DATA_W-1:0] o_mwdata, o_rdata;
  logic [OUT_W-1:0]  o_outst;

  assign o_ready  = (cur == 0) ? ifc_rr.req_ready_o     : ifc_fx.req_ready_o;
  assign o_rsp    = (cur == 0) ? ifc_rr.rsp_valid_o     : ifc_fx.rsp_valid_o;
  assign o_mvld   = (cur == 0) ? ifc_rr.mem_req_valid_o : ifc_fx.mem_req_valid_o;
  assign o_mwe    = (cur == 0) ? ifc_rr.mem_req_we_o    : ifc_fx.mem_req_we_o;
  assign o_maddr  = (cur == 0) ? ifc_rr.mem_req_addr_o  : ifc_fx.mem_req_addr_o;
  assign o_mwdata = (cur == 0) ? ifc_rr.mem_req_wdata_o : ifc_fx.mem_req_wdata_o;
  assign o_rdata  = (cur == 0) ? ifc_rr.rsp_rdata_o     : ifc_fx.rsp_rdata_o;
  assign o_outst  = (cur == 0) ? ifc_rr.outstanding_o   : ifc_fx.outstanding_o;
  assign o_busy   = (cur == 0) ? ifc_rr.busy_o          : ifc_fx.busy_o;
  assign o_err    = (cur == 0) ? ifc_rr.rsp_err_o       : ifc_fx.rsp_err_o;

  // Reference model state
  int                mode;
  int                ptr;
  int                wcnt [NUM_CH];
  int                tagq [$];
  bit                m_vld, m_we, m_err;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  int                mem_acc;
  int                last_g;

  int n_vec, n_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s (dut%0d t=%0t): got %0h expected %0h", tag, cur, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    ptr = 0;
    for (int c = 0; c < NUM_CH; c++) wcnt[c] = 0;
    tagq.delete();
    m_vld = 0; m_we = 0; m_err = 0; m_addr = '0; m_wdata = '0;
    mem_acc = 0;
  endtask

  task automatic retire_grant();
    if (last_g >= 0) vld[last_g] = 1'b0;
    last_g = -1;
  endtask

  // Entered and left at posedge+1; outputs are sampled at posedge+4.
  task automatic do_cycle(input int p_req, input int p_rdy, input int p_rsp, input bit stray);
    logic [NUM_CH-1:0] elig, exp_ready, exp_rsp;
    bit arb, pop;
    int g;
    retire_grant();
    for (int c = 0; c < NUM_CH; c++) begin
      if (!vld[c] && ($urandom % 100) < p_req) begin
        vld[c] = 1'b1;
        we[c]  = 1'($urandom);
        addr[c*ADDR_W +: ADDR_W]  = $urandom;
        wdata[c*DATA_W +: DATA_W] = $urandom;
      end
    end
    mem_ready = (($urandom % 100) < p_rdy);
    rsp_vld   = stray || (mem_acc > 0 && ($urandom % 100) < p_rsp);
    rsp_data  = $urandom;
    #3;
    for (int c = 0; c < NUM_CH; c++) elig[c] = vld[c] & core_en[c / CH_PER_CORE];
    arb = (!m_vld || mem_ready) && (tagq.size() < MAXO);
    g = -1;
    if (arb) begin
      if (mode == 0) begin
        for (int i = 0; i < NUM_CH && g < 0; i++)
          if (elig[(ptr + i) % NUM_CH]) g = (ptr + i) % NUM_CH;
      end else begin
        for (int c = 0; c < NUM_CH && g < 0; c++) if (elig[c] && wcnt[c] >= SL) g = c;
        for (int c = 0; c < NUM_CH && g < 0; c++) if (elig[c]) g = c;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    pop = rsp_vld && tagq.size() > 0;
    exp_rsp = '0;
    if (pop) exp_rsp[tagq[0]] = 1'b1;
    chk("req_ready", 64'(o_ready), 64'(exp_ready));
    chk("rsp_valid", 64'(o_rsp), 64'(exp_rsp));
    chk("rsp_rdata", 64'(o_rdata), 64'(rsp_data));
    chk("mem_req_valid", 64'(o_mvld), 64'(m_vld));
    if (m_vld) begin
      chk("mem_req_we", 64'(o_mwe), 64'(m_we));
      chk("mem_req_addr", 64'(o_maddr), 64'(m_addr));
      chk("mem_req_wdata", 64'(o_mwdata), 64'(m_wdata));
    end
    chk("outstanding", 64'(o_outst), 64'(tagq.size()));
    chk("busy", 64'(o_busy), 64'(m_vld || tagq.size() > 0));
    chk("rsp_err", 64'(o_err), 64'(m_err));
    if (m_vld && mem_ready) mem_acc++;
    if (rsp_vld) begin
      if (tagq.size() > 0) begin
        void'(tagq.pop_front());
        if (mem_acc > 0) mem_acc--;
      end else begin
        m_err = 1;
      end
    end
    if (mode == 1) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!elig[c] || c == g) wcnt[c] = 0;
        else if (arb)           wcnt[c] = (wcnt[c] + 1 > SL) ? SL : wcnt[c] + 1;
      end
    end
    if (g >= 0) begin
      tagq.push_back(g);
      m_vld   = 1;
      m_we    = we[g];
      m_addr  = addr[g*ADDR_W +: ADDR_W];
      m_wdata = wdata[g*DATA_W +: DATA_W];
      if (mode == 0) ptr = (g + 1) % NUM_CH;
      last_g = g;
    end else if (mem_ready) begin
      m_vld = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    retire_grant();
    rst = 1'b1;
    rsp_vld = 1'b0;
    #3;
    chk("rst_req_ready", 64'(o_ready), 64'd0);
    chk("rst_rsp_valid", 64'(o_rsp), 64'd0);
    chk("rst_mem_valid", 64'(o_mvld), 64'd0);
    chk("rst_mem_addr", 64'(o_maddr), 64'd0);
    chk("rst_mem_wdata", 64'(o_mwdata), 64'd0);
    chk("rst_outstanding", 64'(o_outst), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_err", 64'(o_err), 64'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; cur = 0; mode = 0; last_g = -1;
    core_en = '1; vld = '0; we = '0; addr = '0; wdata = '0;
    mem_ready = 1'b0; rsp_vld = 1'b0; rsp_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int inst = 0; inst < 2; inst++) begin
      cur = inst; mode = inst;
      vld = '0; core_en = '1; last_g = -1;
      apply_reset();
      // Saturated load with instant ready and fast responses.
      for (int i = 0; i < 40; i++) do_cycle(100, 100, 100, 1'b0);
      // Only ch0 and ch5 requesting: exposes fixed-priority starvation override.
      for (int i = 0; i < 30; i++) begin
        retire_grant();
        vld[0] = 1'b1; vld[5] = 1'b1;
        do_cycle(0, 100, 100, 1'b0);
      end
      // No responses: the tag FIFO fills and blocks further grants.
      for (int i = 0; i < 12; i++) do_cycle(100, 100, 0, 1'b0);
      for (int i = 0; i < 12; i++) do_cycle(100, 100, 60, 1'b0);
      // Controller stall holds the presented request.
      for (int i = 0; i < 8; i++) do_cycle(100, 0, 50, 1'b0);
      core_en = 4'b1101;
      for (int i = 0; i < 40; i++) do_cycle(80, 80, 60, 1'b0);
      for (int i = 0; i < 300; i++) begin
        if (i % 25 == 0) core_en = 4'($urandom);
        do_cycle(50, 70, 45, 1'b0);
      end
      core_en = '1;
      for (int i = 0; i < 40; i++) do_cycle(0, 100, 100, 1'b0);
      // Drained: a stray response must set the sticky error.
      do_cycle(0, 100, 0, 1'b1);
      for (int i = 0; i < 5; i++) do_cycle(0, 100, 0, 1'b0);
      // Reset with requests in flight, then a late response from before the reset.
      for (int i = 0; i < 20; i++) do_cycle(70, 60, 20, 1'b0);
      apply_reset();
      do_cycle(0, 100, 0, 1'b1);
      for (int i = 0; i < 20; i++) do_cycle(60, 70, 50, 1'b0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
